// File: rtl/vend_ctrl_multi.sv
// Multi-product vending controller: coin accumulation, priced selection, vend strobe,
// and change/refund returned as bounded units over a valid/ready handshake.
module vend_ctrl_multi #(
   parameter int unsigned COIN_W   = 5,
   parameter int unsigned BAL_W    = 7,
   parameter int unsigned N_PROD   = 4,
   parameter int unsigned SEL_W    = 2,
   parameter int unsigned CHG_UNIT = 10
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    coin_valid,
   input  logic [COIN_W-1:0]       coin_val,
   output logic                    coin_ready,
   output logic                    coin_rej,
   input  logic                    sel_valid,
   input  logic [SEL_W-1:0]        sel_id,
   output logic                    sel_rej,
   input  logic                    cancel,
   input  logic [N_PROD*BAL_W-1:0] prices,
   output logic                    vend,
   output logic [SEL_W-1:0]        vend_id,
   output logic                    chg_valid,
   output logic [BAL_W-1:0]        chg_amt,
   input  logic                    chg_ready,
   output logic [BAL_W-1:0]        balance
);

   localparam logic [BAL_W:0]   BalMax  = {1'b0, {BAL_W{1'b1}}};
   localparam logic [BAL_W-1:0] ChgUnit = BAL_W'(CHG_UNIT);

   typedef enum logic [1:0] {StAccum, StVend, StChange} state_e;

   state_e            state_q, state_d;
   logic [BAL_W-1:0]  bal_q, bal_d;
   logic [BAL_W-1:0]  price_q, price_d;
   logic [SEL_W-1:0]  vend_id_q, vend_id_d;
   logic              coin_rej_q, coin_rej_d;
   logic              sel_rej_q, sel_rej_d;

   logic              coin_fire;
   logic              coin_ok;
   logic [BAL_W:0]    coin_sum;
   logic [BAL_W-1:0]  bal_acc;
   logic [BAL_W-1:0]  sel_price;
   logic              sel_in_range;
   logic [BAL_W-1:0]  bal_after_vend;
   logic [BAL_W-1:0]  bal_after_chg;

   assign coin_ready = (state_q == StAccum);
   assign vend       = (state_q == StVend);
   assign vend_id    = vend_id_q;
   assign chg_valid  = (state_q == StChange);
   assign chg_amt    = chg_valid ? ((bal_q < ChgUnit) ? bal_q : ChgUnit) : '0;
   assign coin_rej   = coin_rej_q;
   assign sel_rej    = sel_rej_q;
   assign balance    = bal_q;

   // Overflow is detected in one extra bit so the balance can never wrap.
   assign coin_fire = coin_valid & coin_ready;
   assign coin_sum  = {1'b0, bal_q} + (BAL_W + 1)'(coin_val);
   assign coin_ok   = (coin_sum <= BalMax);
   assign bal_acc   = (coin_fire && coin_ok) ? coin_sum[BAL_W-1:0] : bal_q;

   assign sel_in_range   = (32'(sel_id) < N_PROD);
   assign bal_after_vend = bal_q - price_q;
   assign bal_after_chg  = bal_q - chg_amt;

   always_comb begin
      sel_price = '0;
      for (int i = 0; i < int'(N_PROD); i++) begin
         if (32'(sel_id) == i) sel_price = prices[i*BAL_W +: BAL_W];
      end
   end

   always_comb begin
      state_d    = state_q;
      bal_d      = bal_q;
      price_d    = price_q;
      vend_id_d  = vend_id_q;
      coin_rej_d = 1'b0;
      sel_rej_d  = 1'b0;
      unique case (state_q)
         StAccum: begin
            bal_d      = bal_acc;
            coin_rej_d = coin_fire && !coin_ok;
            if (cancel) begin
               if (bal_acc != '0) state_d = StChange;
            end else if (sel_valid) begin
               // Affordability uses the registered balance; a same-cycle coin still lands.
               if (!sel_in_range || sel_price == '0 || bal_q < sel_price) begin
                  sel_rej_d = 1'b1;
               end else begin
                  price_d   = sel_price;
                  vend_id_d = sel_id;
                  state_d   = StVend;
               end
            end
         end
         StVend: begin
            bal_d   = bal_after_vend;
            state_d = (bal_after_vend != '0) ? StChange : StAccum;
         end
         StChange: begin
            if (chg_ready) begin
               bal_d = bal_after_chg;
               if (bal_after_chg == '0) state_d = StAccum;
            end
         end
         default: state_d = StAccum;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StAccum;
         bal_q      <= '0;
         price_q    <= '0;
         vend_id_q  <= '0;
         coin_rej_q <= 1'b0;
         sel_rej_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         bal_q      <= bal_d;
         price_q    <= price_d;
         vend_id_q  <= vend_id_d;
         coin_rej_q <= coin_rej_d;
         sel_rej_q  <= sel_rej_d;
      end
   end

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// Scoreboard bench for vend_ctrl_multi: stimulus pushes expected output events, a negedge
// monitor pops and compares them; balance and handshake levels are checked directly.
module tb_vend_ctrl_multi;

   localparam int COIN_W = 5;
   localparam int BAL_W  = 7;
   localparam int N_PROD = 4;
   localparam int SEL_W  = 2;

   localparam int EvVend = 0;
   localparam int EvChg  = 1;
   localparam int EvCRej = 2;
   localparam int EvSRej = 3;

   typedef struct {
      int kind;
      int val;
   } ev_t;

   logic                    clk = 1'b0;
   logic                    rst = 1'b0;
   logic                    coin_valid = 1'b0;
   logic [COIN_W-1:0]       coin_val = '0;
   logic                    coin_ready;
   logic                    coin_rej;
   logic                    sel_valid = 1'b0;
   logic [SEL_W-1:0]        sel_id = '0;
   logic                    sel_rej;
   logic                    cancel = 1'b0;
   logic [N_PROD*BAL_W-1:0] prices;
   logic                    vend;
   logic [SEL_W-1:0]        vend_id;
   logic                    chg_valid;
   logic [BAL_W-1:0]        chg_amt;
   logic                    chg_ready = 1'b1;
   logic [BAL_W-1:0]        balance;

   int  n_tests = 0;
   int  n_fail  = 0;
   ev_t exp_q[$];

   assign prices = {7'd0, 7'd60, 7'd25, 7'd40};

   vend_ctrl_multi dut (
      .clk        (clk),
      .rst        (rst),
      .coin_valid (coin_valid),
      .coin_val   (coin_val),
      .coin_ready (coin_ready),
      .coin_rej   (coin_rej),
      .sel_valid  (sel_valid),
      .sel_id     (sel_id),
      .sel_rej    (sel_rej),
      .cancel     (cancel),
      .prices     (prices),
      .vend       (vend),
      .vend_id    (vend_id),
      .chg_valid  (chg_valid),
      .chg_amt    (chg_amt),
      .chg_ready  (chg_ready),
      .balance    (balance)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   function automatic void push(input int k, input int v);
      ev_t e;
      e.kind = k;
      e.val  = v;
      exp_q.push_back(e);
   endfunction

   task automatic mon_pop(input string nm, input int k, input int v);
      ev_t e;
      n_tests++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL %s: unexpected event value %0d, none expected", nm, v);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != k || e.val != v) begin
            n_fail++;
            $display("FAIL %s: got kind %0d value %0d, expected kind %0d value %0d",
                     nm, k, v, e.kind, e.val);
         end
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         if (vend)                  mon_pop("vend", EvVend, int'(vend_id));
         if (chg_valid && chg_ready) mon_pop("chg", EvChg, int'(chg_amt));
         if (coin_rej)              mon_pop("coin_rej", EvCRej, 0);
         if (sel_rej)               mon_pop("sel_rej", EvSRej, 0);
      end
   end

   task automatic coin(input int v);
      coin_valid = 1'b1;
      coin_val   = COIN_W'(v);
      @(posedge clk); #1;
      coin_valid = 1'b0;
   endtask

   task automatic sel(input int id, input bit with_cancel);
      sel_valid = 1'b1;
      sel_id    = SEL_W'(id);
      cancel    = with_cancel;
      @(posedge clk); #1;
      sel_valid = 1'b0;
      cancel    = 1'b0;
   endtask

   task automatic do_cancel();
      cancel = 1'b1;
      @(posedge clk); #1;
      cancel = 1'b0;
   endtask

   task automatic wait_accum(input string nm);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!coin_ready && n < 60);
      chk({nm, "_timeout"}, int'(coin_ready), 1);
      @(posedge clk); #1;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      // Reset mid-refund: balance is dropped with no change issued.
      chg_ready = 1'b0;
      coin(20);
      coin(20);
      do_cancel();
      @(negedge clk);
      chk("rst_pre_chg_valid", int'(chg_valid), 1);
      chk("rst_pre_chg_amt", int'(chg_amt), 10);
      @(posedge clk); #1;
      rst = 1'b0;
      #2;
      chk("rst_balance", int'(balance), 0);
      chk("rst_chg_valid", int'(chg_valid), 0);
      chk("rst_chg_amt", int'(chg_amt), 0);
      chk("rst_vend", int'(vend), 0);
      chk("rst_vend_id", int'(vend_id), 0);
      chk("rst_rejs", int'({coin_rej, sel_rej}), 0);
      @(posedge clk); #1;
      rst = 1'b1;
      chg_ready = 1'b1;
      @(posedge clk); #1;
      chk("rst_coin_ready", int'(coin_ready), 1);
      chk("rst_balance_after", int'(balance), 0);

      // Exact payment: vend product 0, no change.
      coin(5); coin(20); coin(5); coin(10);
      chk("exact_bal", int'(balance), 40);
      push(EvVend, 0);
      sel(0, 1'b0);
      wait_accum("exact");
      chk("exact_bal_end", int'(balance), 0);

      // Overpay 50 for product 1 (25): change 10,10,5.
      coin(20); coin(20); coin(10);
      push(EvVend, 1);
      push(EvChg, 10); push(EvChg, 10); push(EvChg, 5);
      sel(1, 1'b0);
      wait_accum("overpay");
      chk("overpay_bal_end", int'(balance), 0);

      // Rejections at balance 30, then cancel beats a valid selection.
      coin(10); coin(20);
      push(EvSRej, 0);
      sel(2, 1'b0);
      chk("rej_poor_bal", int'(balance), 30);
      push(EvSRej, 0);
      sel(3, 1'b0);
      chk("rej_zero_bal", int'(balance), 30);
      push(EvChg, 10); push(EvChg, 10); push(EvChg, 10);
      sel(1, 1'b1);
      wait_accum("cancel");
      chk("cancel_bal_end", int'(balance), 0);

      // Saturation: 120 + 10 refused, 120 + 5 fits exactly.
      repeat (6) coin(20);
      chk("sat_bal_120", int'(balance), 120);
      push(EvCRej, 0);
      coin(10);
      chk("sat_bal_rej", int'(balance), 120);
      coin(5);
      chk("sat_bal_125", int'(balance), 125);
      repeat (12) push(EvChg, 10);
      push(EvChg, 5);
      do_cancel();
      wait_accum("sat_refund");
      chk("sat_bal_end", int'(balance), 0);

      // Selection with same-cycle coin: compare against 30, coin still lands.
      coin(10); coin(20);
      push(EvVend, 1);
      push(EvChg, 10); push(EvChg, 5);
      coin_valid = 1'b1;
      coin_val   = 5'd10;
      sel(1, 1'b0);
      coin_valid = 1'b0;
      chk("samecyc_bal", int'(balance), 40);
      wait_accum("samecyc");
      chk("samecyc_bal_end", int'(balance), 0);

      // Hopper stall: change unit stable, coins ignored.
      chg_ready = 1'b0;
      coin(20);
      do_cancel();
      coin_valid = 1'b1;
      coin_val   = 5'd5;
      repeat (3) begin
         @(negedge clk);
         chk("stall_chg_valid", int'(chg_valid), 1);
         chk("stall_chg_amt", int'(chg_amt), 10);
         chk("stall_coin_ready", int'(coin_ready), 0);
         chk("stall_bal", int'(balance), 20);
      end
      @(posedge clk); #1;
      coin_valid = 1'b0;
      push(EvChg, 10); push(EvChg, 10);
      chg_ready = 1'b1;
      wait_accum("stall");
      chk("stall_bal_end", int'(balance), 0);

      repeat (3) @(posedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/vend_ctrl_multi.md
Name: vend_ctrl_multi

Overview:
- Parametrised vending controller for multiple products.
- Accepts coins over a valid/ready handshake and accumulates a saturating-safe balance.
- Serves a product selection against a per-product price table; a 0 price disables that product.
- Returns change or a refund as a stream of bounded change units over a valid/ready handshake.
- Sits between the coin-feed front end and the dispenser/change-hopper back end.

Parameters:
- COIN_W, 5: coin value width.
- BAL_W, 7: balance/price width; BAL_MAX = 2^BAL_W-1.
- N_PROD, 4: number of products.
- SEL_W, 2: product select width; must satisfy 2^SEL_W >= N_PROD.
- CHG_UNIT, 10: largest amount returned per change transfer.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- coin_valid  in  1  coin offered.
- coin_val  in  COIN_W  coin value.
- coin_ready  out  1  controller can accept a coin.
- coin_rej  out  1  one-cycle pulse: offered coin refused because it would overflow the balance.
- sel_valid  in  1  product selection request.
- sel_id  in  SEL_W  product index.
- sel_rej  out  1  one-cycle pulse: selection refused.
- cancel  in  1  refund request.
- prices  in  N_PROD*BAL_W  price table; product i occupies bits [i*BAL_W +: BAL_W].
- vend  out  1  one-cycle dispense strobe.
- vend_id  out  SEL_W  product dispensed; valid while vend=1.
- chg_valid  out  1  change unit offered.
- chg_amt  out  BAL_W  change amount of the current unit.
- chg_ready  in  1  hopper accepts the change unit.
- balance  out  BAL_W  registered current balance.

Behaviour:
- Reset state: ACCUM. Reset values: balance=0, vend=0, vend_id=0, coin_rej=0, sel_rej=0, chg_valid=0, chg_amt=0.
- Reset applies immediately, from any state, mid-operation. Balance is lost; no refund is issued.
- Outputs vend, vend_id, coin_rej, sel_rej, chg_valid and chg_amt are registered or decoded from state only. None depends combinationally on inputs.
- coin_ready = 1 only in ACCUM.
- States: ACCUM, VEND, CHANGE.
- ACCUM, coin handling (coin_valid & coin_ready):
  - If balance + coin_val <= BAL_MAX: add the coin to the balance at the edge.
  - Otherwise: balance unchanged; coin_rej = 1 for the next cycle.
- ACCUM, command priority: cancel > sel_valid.
- ACCUM, cancel:
  - If balance_next > 0, go to CHANGE (refund). balance_next includes a coin accepted in the same cycle.
  - Otherwise stay in ACCUM; no effect.
- ACCUM, sel_valid (no cancel):
  - Look up p = prices[sel_id].
  - Reject (sel_rej pulse next cycle, stay in ACCUM, balance kept) if any of: sel_id >= N_PROD; p == 0; balance < p.
  - The comparison uses the registered balance, before any same-cycle coin. A same-cycle coin is still added.
  - On accept: latch sel_id and p, go to VEND.
- VEND, exactly 1 cycle:
  - vend = 1, vend_id = latched id.
  - At the edge ending VEND, balance -= p.
  - Next state: CHANGE if the new balance > 0, else ACCUM.
  - Latency: sel accepted at edge k → vend high in cycle k..k+1 → balance updated at edge k+1.
- CHANGE:
  - chg_valid = 1; chg_amt = min(balance, CHG_UNIT).
  - On chg_ready: balance -= chg_amt.
  - When the balance reaches 0, go to ACCUM; chg_valid drops in that same edge.
  - chg_amt and chg_valid stay stable while chg_ready = 0.
  - Coins, sel_valid and cancel are ignored; coin_ready = 0.
- Arithmetic:
  - Addition is computed in BAL_W+1 bits to detect overflow.
  - coin_val is zero-extended.
  - Balance never wraps and never goes negative.

Test Plan:
- Defaults, prices={40,25,60,0}. Assert rst mid-stream → all outputs 0, balance 0, coin_ready=1 one cycle after release.
- Coins 5,20,5,10, then sel 0 → vend pulses 1 cycle with vend_id=0; balance 40→0; chg_valid never asserted; back in ACCUM.
- Coins 20,20,10 (50), then sel 1 → vend_id=1; balance 25; change units 10,10,5 with chg_ready=1; then ACCUM, balance 0.
- Balance 30:
  - sel 2 → sel_rej, balance 30.
  - sel 3 (price 0) → sel_rej.
  - sel together with cancel → cancel wins; change 10,10,10; no vend.
- Six coins of 20 (120), then coin 10 → coin_rej, balance 120; coin 5 → balance 125.
- Balance 30, sel 1 together with coin 10 → compare uses 30 (accepted); balance 40-25=15; change 10,5.
- Hold chg_ready=0 for 3 cycles → chg_valid=1 and chg_amt=10 stable; coin_valid is ignored (coin_ready=0).
